aes_inv_round_seq: RTL

//  Iterative AES decryption sequencer sitting directly upstream of the 2-stage inverse round.
//  - Accepts one 128-bit ciphertext block over a valid/ready handshake.
//  - Performs the initial AddRoundKey with rk[NR] itself.
//  - Then drives the inverse round NR times, feeding each round result back as the next input.
//  - Fetches round keys from the key store by index and returns the plaintext over a valid/ready output.

---
 rtl/aes_inv_round_seq_if.sv | 32 +++
 rtl/aes_inv_round_seq.sv | 99 +++++++++
 2 files changed

// File: rtl/aes_inv_round_seq_if.sv
// rtl/aes_inv_round_seq_if.sv - block, key-store and inverse-round signals of the decrypt sequencer
interface aes_inv_round_seq_if #(
  parameter int KEY_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [127:0]      in_block;
  logic [KEY_AW-1:0] rk_addr;
  logic [127:0]      rk_data;
  logic [127:0]      round_state_in;
  logic [127:0]      round_key;
  logic              sel_inv_mix_col;
  logic [127:0]      round_state_out;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
  logic              busy;

  // Sequencer side
  modport master (
    input  in_valid, in_block, rk_data, round_state_out, out_ready,
    output in_ready, rk_addr, round_state_in, round_key, sel_inv_mix_col,
           out_valid, out_block, busy
  );

  // Environment side: block source/sink, key store, inverse round
  modport slave (
    output in_valid, in_block, rk_data, round_state_out, out_ready,
    input  in_ready, rk_addr, round_state_in, round_key, sel_inv_mix_col,
           out_valid, out_block, busy
  );
endinterface

// File: rtl/aes_inv_round_seq.sv
// rtl/aes_inv_round_seq.sv - iterative AES decryption sequencer around a pipelined inverse round
module aes_inv_round_seq #(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 2,
  parameter int KEY_AW    = 4
) (
  input logic                 clk,
  input logic                 rst,
  aes_inv_round_seq_if.master bus
);

  localparam int                CW       = (ROUND_LAT > 0) ? $clog2(ROUND_LAT + 1) : 1;
  localparam logic [KEY_AW-1:0] KEY_LAST = KEY_AW'(NR);
  localparam logic [KEY_AW-1:0] KEY_ONE  = KEY_AW'(1);
  localparam logic [CW-1:0]     CNT_LAST = CW'(ROUND_LAT);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} state_t;

  state_t       state;
  logic [127:0] captured;
  logic [CW-1:0] wait_cnt;

  // The round engine takes the key straight from the key store; rk_addr is
  // already held stable for the whole round, so no extra register is needed.
  assign bus.round_key = bus.rk_data;

  // Sequencer FSM; rk_addr doubles as the round index r.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= IDLE;
      captured           <= '0;
      wait_cnt           <= '0;
      bus.in_ready       <= 1'b0;
      bus.busy           <= 1'b0;
      bus.rk_addr        <= '0;
      bus.round_state_in <= '0;
      bus.sel_inv_mix_col <= 1'b0;
      bus.out_valid      <= 1'b0;
      bus.out_block      <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready        <= 1'b1;
          bus.busy            <= 1'b0;
          bus.rk_addr         <= KEY_LAST;
          bus.sel_inv_mix_col <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            captured     <= bus.in_block;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            state        <= LOAD;
          end
        end

        LOAD: begin
          // Initial AddRoundKey with rk[NR], then start the first inverse round.
          bus.round_state_in  <= captured ^ bus.rk_data;
          bus.rk_addr         <= KEY_LAST - KEY_ONE;
          bus.sel_inv_mix_col <= (NR > 1);
          wait_cnt            <= '0;
          state               <= ROUND;
        end

        ROUND: begin
          if (wait_cnt == CNT_LAST) begin
            if (bus.rk_addr != '0) begin
              bus.round_state_in  <= bus.round_state_out;
              bus.rk_addr         <= bus.rk_addr - KEY_ONE;
              bus.sel_inv_mix_col <= (bus.rk_addr != KEY_ONE);
              wait_cnt            <= '0;
            end else begin
              bus.out_block <= bus.round_state_out;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            // Leave with IDLE's outputs already in place so a block can be
            // accepted in the very next cycle.
            bus.out_valid       <= 1'b0;
            bus.in_ready        <= 1'b1;
            bus.busy            <= 1'b0;
            bus.rk_addr         <= KEY_LAST;
            bus.sel_inv_mix_col <= 1'b1;
            state               <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
